// File: rtl/aes_pkg.sv
// Controller state encoding, round constants and GF(2^8) helpers for the AES round logic.
`include "aes_defines.svh"

package aes_pkg;

  localparam int unsigned AES_ROUNDS      = 10;
  localparam int unsigned KEY_INDEX_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } ctrl_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/aes_round_controller_if.sv
// Block I/O and round-key lookup signals of the round controller.
`include "aes_defines.svh"

interface aes_round_controller_if;
  import aes_pkg::*;

  logic                         Encrypt;
  logic                         Input_valid;
  logic                         Input_ready;
  logic [`AES_BLOCK_SIZE-1:0]   Input_block;
  logic [KEY_INDEX_WIDTH-1:0]   Key_index;
  logic [`AES_BLOCK_SIZE-1:0]   Round_key;
  logic                         Output_valid;
  logic                         Output_ready;
  logic [`AES_BLOCK_SIZE-1:0]   Output_block;

  modport master (
    output Encrypt, Input_valid, Input_block, Round_key, Output_ready,
    input  Input_ready, Key_index, Output_valid, Output_block
  );

  modport slave (
    input  Encrypt, Input_valid, Input_block, Round_key, Output_ready,
    output Input_ready, Key_index, Output_valid, Output_block
  );
endinterface

// File: rtl/aes_defines.svh
// Shared width macro for the AES datapath.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH
`define AES_BLOCK_SIZE 128
`endif

// File: rtl/aes_round.sv
// Combinational AES round (forward or inverse) and its S-box, row-shifter and column-mixer blocks.
`include "aes_defines.svh"

module aes_sbox
  import aes_pkg::*;
(
  input  logic       Inverse,
  input  logic [7:0] In_byte,
  output logic [7:0] Out_byte
);
  logic [7:0] inv_in;
  logic [7:0] inv_out;

  // One field inversion serves both directions; only the affine step moves sides.
  always_comb begin
    inv_in   = Inverse ? inv_affine(In_byte) : In_byte;
    inv_out  = gf_inv(inv_in);
    Out_byte = Inverse ? inv_out : affine(inv_out);
  end
endmodule

module aes_shift_rows (
  input  logic                       Inverse,
  input  logic [`AES_BLOCK_SIZE-1:0] In_block,
  output logic [`AES_BLOCK_SIZE-1:0] Out_block
);
  always_comb begin
    int unsigned src;
    Out_block = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src = Inverse ? (c + 4 - r) % 4 : (c + r) % 4;
        Out_block[127 - 8*(r + 4*c) -: 8] = In_block[127 - 8*(r + 4*src) -: 8];
      end
    end
  end
endmodule

module aes_mix_columns
  import aes_pkg::*;
(
  input  logic        Inverse,
  input  logic [31:0] In_col,
  output logic [31:0] Out_col
);
  logic [31:0] coef_row;

  always_comb begin
    logic [7:0] acc;
    coef_row = Inverse ? 32'h0e0b0d09 : 32'h02030101;
    Out_col  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      acc = '0;
      for (int unsigned j = 0; j < 4; j++) begin
        acc = acc ^ gf_mul(In_col[31 - 8*j -: 8], coef_row[31 - 8*((j + 4 - i) % 4) -: 8]);
      end
      Out_col[31 - 8*i -: 8] = acc;
    end
  end
endmodule

module aes_round (
  input  logic                       Encrypt,
  input  logic                       Final,
  input  logic [`AES_BLOCK_SIZE-1:0] In_block,
  input  logic [`AES_BLOCK_SIZE-1:0] Round_key,
  output logic [`AES_BLOCK_SIZE-1:0] Out_block
);
  logic                       inverse;
  logic [`AES_BLOCK_SIZE-1:0] shifted;
  logic [`AES_BLOCK_SIZE-1:0] subbed;
  logic [`AES_BLOCK_SIZE-1:0] added;
  logic [`AES_BLOCK_SIZE-1:0] mix_in;
  logic [`AES_BLOCK_SIZE-1:0] mixed;

  assign inverse = ~Encrypt;

  // Row shifting and byte substitution commute, so both directions shift first.
  aes_shift_rows u_shift (
    .Inverse   (inverse),
    .In_block  (In_block),
    .Out_block (shifted)
  );

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .Inverse  (inverse),
      .In_byte  (shifted[8*i +: 8]),
      .Out_byte (subbed[8*i +: 8])
    );
  end

  // The single mixer sees the substituted state when encrypting, the keyed state when decrypting.
  assign added  = subbed ^ Round_key;
  assign mix_in = Encrypt ? subbed : added;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mix_columns u_mix (
      .Inverse (inverse),
      .In_col  (mix_in[127 - 32*c -: 32]),
      .Out_col (mixed[127 - 32*c -: 32])
    );
  end

  always_comb begin
    if (Encrypt) Out_block = (Final ? subbed : mixed) ^ Round_key;
    else         Out_block = Final ? added : mixed;
  end
endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES-128 controller: accepts a block, runs 10 rounds on one shared datapath, returns the result.
`include "aes_defines.svh"

module aes_round_controller
  import aes_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Rst,
  aes_round_controller_if.slave   bus
);
  ctrl_state_e                state_q, state_d;
  logic [`AES_BLOCK_SIZE-1:0] blk_q, blk_d;
  logic                       mode_q, mode_d;
  logic [KEY_INDEX_WIDTH-1:0] round_cnt_q, round_cnt_d;
  logic                       out_valid_q, out_valid_d;

  logic [`AES_BLOCK_SIZE-1:0] round_out;
  logic                       final_round;
  logic                       load;

  assign final_round = (round_cnt_q == KEY_INDEX_WIDTH'(AES_ROUNDS));

  aes_round u_round (
    .Encrypt   (mode_q),
    .Final     (final_round),
    .In_block  (blk_q),
    .Round_key (bus.Round_key),
    .Out_block (round_out)
  );

  // Key index and readiness stay free of Round_key so the external key lookup forms no loop.
  always_comb begin
    bus.Input_ready = 1'b0;
    bus.Key_index   = bus.Encrypt ? '0 : KEY_INDEX_WIDTH'(AES_ROUNDS);
    load            = 1'b0;
    case (state_q)
      IDLE: begin
        bus.Input_ready = 1'b1;
        load            = bus.Input_valid;
      end
      ROUND: begin
        bus.Key_index = mode_q ? round_cnt_q : KEY_INDEX_WIDTH'(AES_ROUNDS) - round_cnt_q;
      end
      DONE: begin
        bus.Input_ready = bus.Output_ready;
        load            = bus.Output_ready & bus.Input_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    mode_d      = mode_q;
    round_cnt_d = round_cnt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: ;
      ROUND: begin
        blk_d = round_out;
        if (final_round) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          round_cnt_d = round_cnt_q + KEY_INDEX_WIDTH'(1);
        end
      end
      DONE: begin
        if (bus.Output_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      blk_d       = bus.Input_block ^ bus.Round_key;
      mode_d      = bus.Encrypt;
      round_cnt_d = KEY_INDEX_WIDTH'(1);
      state_d     = ROUND;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      mode_q      <= 1'b1;
      round_cnt_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      mode_q      <= mode_d;
      round_cnt_q <= round_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.Output_valid = out_valid_q;
  assign bus.Output_block = blk_q;
endmodule

// File: doc/aes_round_controller.md
# aes_round_controller

Iterative AES-128 cipher controller. It accepts one 128-bit block over a ready/valid handshake, applies the initial AddRoundKey, and then sequences a single shared round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey, or their inverses) for 10 rounds. It addresses an external round-key store and returns the result over a ready/valid handshake with backpressure. It sits between the block-level I/O adapter and the key-schedule storage, and owns the only instance of the round datapath.

## Interface
Parameters:
- none; widths come from `AES_BLOCK_SIZE` (128) and package constants.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Encrypt  input  1  1 = encrypt, 0 = decrypt; sampled only on input handshake.
- Input_valid  input  1  Input_block is valid.
- Input_ready  output  1  controller can accept a block this cycle.
- Input_block  input  128  plaintext or ciphertext.
- Key_index  output  4  round-key index requested, 0..10.
- Round_key  input  128  key selected by Key_index, same cycle (combinational read).
- Output_valid  output  1  Output_block holds a finished result.
- Output_ready  input  1  consumer accepts result.
- Output_block  output  128  result; stable while Output_valid && !Output_ready.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE:
  - Input_ready = 1; Key_index = Encrypt ? 0 : 10.
  - On accept: state_reg <= Input_block ^ Round_key; mode_reg <= Encrypt; round_cnt <= 1; go to ROUND.
- ROUND:
  - Key_index = mode_reg ? round_cnt : 10 - round_cnt.
  - state_reg <= aes_round(state_reg, Round_key, mode_reg, Final = (round_cnt == 10)).
  - round_cnt increments each cycle; after the cycle with round_cnt == 10, go to DONE.
- Round datapath ordering:
  - Encrypt: SubBytes, ShiftRows, MixColumns (skipped when Final), AddRoundKey.
  - Decrypt: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (skipped when Final).
- DONE:
  - Output_valid = 1; Output_block = state_reg.
  - On Output_ready, the result is consumed.
  - Input_ready = Output_ready (back-to-back). If Input_valid is also high, load the new block exactly as in IDLE and go to ROUND. Otherwise go to IDLE.
- Encrypt and Input_block changes while busy are ignored; mode is latched.
- Input_ready = 0 in ROUND, and in DONE while Output_ready = 0.
- Key_index in DONE reflects the input-side start index, because it feeds a possible back-to-back load.

## Timing
- Reset values: state IDLE, Output_valid 0, Output_block 0 (state_reg cleared), Input_ready 1, Key_index 0 (with Encrypt = 1; otherwise it follows Encrypt combinationally), round_cnt 0.
- Latency: accept at cycle 0 gives Output_valid high at cycle 11.
- Throughput: one block per 11 cycles with Output_ready held high; no bubble on back-to-back traffic.
- Output_valid falls the cycle after the handshake, unless a new block is loaded (it still falls; the new result arrives 11 cycles later).
- Rst asserted mid-operation: the in-flight block is dropped, the controller is in IDLE next cycle, and no Output_valid is produced for that block.
- round_cnt is 4 bits; it never exceeds 10 and never wraps.

## Structure
- Package aes_pkg holds:
  - the state enum (IDLE/ROUND/DONE);
  - AES_ROUNDS = 10;
  - KEY_INDEX_WIDTH = 4.
- `AES_BLOCK_SIZE` stays in aes_defines.svh.
- Sub-module aes_round is purely combinational (Encrypt, Final, In_block, Round_key → Out_block). It instantiates the S-box, rows-shifter and column-mixer blocks.
- The controller holds only the FSM, counter, mode and state registers.

## Test plan
- FIPS-197 C.1 encrypt: load keys 0..10 from key 000102…0f, feed 00112233445566778899aabbccddeeff with Encrypt = 1. Output 69c4e0d86a7b0430d8cdb78070b4c55a at cycle 11, with Key_index sequence 0,1,…,10.
- Decrypt: feed 69c4e0d86a7b0430d8cdb78070b4c55a with Encrypt = 0. Output 00112233445566778899aabbccddeeff, with Key_index sequence 10,9,…,0.
- Backpressure: hold Output_ready = 0 for 5 cycles after Output_valid. Output_block must stay stable, Input_ready = 0, and Input_valid is ignored.
- Back-to-back: Input_valid and Output_ready both held high with alternating Encrypt. Blocks must be accepted every 11 cycles with correct results.
- Mid-op reset: assert Rst at cycle 5 of a block. Next cycle all outputs are at reset values, and a fresh block then completes correctly.
- Mode stability: toggle Encrypt every cycle during ROUND. The result must match the mode sampled at accept.
